// File: rtl/vi_fc_pkg.sv
// rtl/vi_fc_pkg.sv - shared types, defaults and word classifier for the FC link monitor
package vi_fc_pkg;

  typedef enum logic [2:0] {
    PS_NONE = 3'd0,
    PS_NOS  = 3'd1,
    PS_OLS  = 3'd2,
    PS_LR   = 3'd3,
    PS_LRR  = 3'd4
  } prim_seq_e;

  typedef enum logic [1:0] {
    LS_DOWN  = 2'd0,
    LS_FAIL  = 2'd1,
    LS_RESET = 2'd2,
    LS_UP    = 2'd3
  } link_state_e;

  typedef enum logic [2:0] {
    WC_NOS, WC_OLS, WC_LR, WC_LRR, WC_SOF, WC_EOF, WC_IDLE, WC_OTHER
  } word_class_e;

  localparam int IDLE_RUN_DEF = 3;

  // Simultaneous flags resolve by fixed priority so exactly one class acts per word.
  function automatic word_class_e classify(input logic sof, input logic eof, input logic idle,
                                           input logic nos, input logic ols, input logic lr,
                                           input logic lrr);
    if (nos)  return WC_NOS;
    if (ols)  return WC_OLS;
    if (lr)   return WC_LR;
    if (lrr)  return WC_LRR;
    if (sof)  return WC_SOF;
    if (eof)  return WC_EOF;
    if (idle) return WC_IDLE;
    return WC_OTHER;
  endfunction

  function automatic prim_seq_e class_to_prim(input word_class_e c);
    case (c)
      WC_NOS:  return PS_NOS;
      WC_OLS:  return PS_OLS;
      WC_LR:   return PS_LR;
      WC_LRR:  return PS_LRR;
      default: return PS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vi_fc_sat_cnt.sv
// rtl/vi_fc_sat_cnt.sv - saturating up-counter with sync clear and increment enable
// clr together with inc restarts the count at one.
module vi_fc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst || (clr && !inc)) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= ONE;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/vi_fc_link_mon.sv
// rtl/vi_fc_link_mon.sv - FC primitive-sequence, link-state and frame monitor
// Statistics counters are built only when VI_FC_LINK_MON_STATS_EN is defined.
module vi_fc_link_mon
  import vi_fc_pkg::*;
#(
  parameter int IDLE_RUN = IDLE_RUN_DEF,
`ifdef VI_FC_LINK_MON_STATS_EN
  parameter int CNT_W    = 32,
`endif
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_vld,
  input  logic             sof,
  input  logic             eof,
  input  logic             idle,
  input  logic             nos,
  input  logic             ols,
  input  logic             lr,
  input  logic             lrr,
  output logic [2:0]       prim_seq,
  output logic [1:0]       link_state,
  output logic             in_frame,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             err_sof,
  output logic             err_eof,
`ifdef VI_FC_LINK_MON_STATS_EN
  output logic             err_abort,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_errs,
  output logic [CNT_W-1:0] stat_fails
`else
  output logic             err_abort
`endif
);

  localparam logic [3:0]       IDLE_RUN_L = 4'(IDLE_RUN);
  localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

  word_class_e      cls, last_q;
  logic             is_ps, run_hit, idle_hit;
  logic             done_ev, esof_ev, eeof_ev, abort_ev, len_clr, len_inc;
  logic [1:0]       run_q, run_n;
  logic [3:0]       idle_q, idle_n;
  logic [LEN_W-1:0] len_q;

  always_comb begin
    cls    = classify(sof, eof, idle, nos, ols, lr, lrr);
    is_ps  = (cls == WC_NOS) || (cls == WC_OLS) || (cls == WC_LR) || (cls == WC_LRR);
    run_n  = 2'd0;
    if (is_ps) begin
      if (cls != last_q)      run_n = 2'd1;
      else if (run_q != 2'd3) run_n = run_q + 2'd1;
      else                    run_n = 2'd3;
    end
    idle_n = 4'd0;
    if (cls == WC_IDLE) idle_n = (idle_q == 4'hf) ? idle_q : idle_q + 4'd1;
    run_hit  = word_vld && (run_n == 2'd3);
    idle_hit = word_vld && (idle_n >= IDLE_RUN_L);
    done_ev  = word_vld && (cls == WC_EOF) && in_frame;
    eeof_ev  = word_vld && (cls == WC_EOF) && !in_frame;
    esof_ev  = word_vld && (cls == WC_SOF) && in_frame;
    abort_ev = word_vld && is_ps && in_frame;
    len_clr  = word_vld && (cls == WC_SOF);
    len_inc  = len_clr || (word_vld && in_frame && ((cls == WC_IDLE) || (cls == WC_OTHER)));
  end

  vi_fc_sat_cnt #(.W(LEN_W)) u_len (
    .clk (clk),
    .rst (rst),
    .clr (len_clr),
    .inc (len_inc),
    .cnt (len_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= WC_OTHER;
      run_q      <= 2'd0;
      idle_q     <= 4'd0;
      prim_seq   <= PS_NONE;
      link_state <= LS_DOWN;
      in_frame   <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      err_sof    <= 1'b0;
      err_eof    <= 1'b0;
      err_abort  <= 1'b0;
    end else begin
      frame_done <= done_ev;
      err_sof    <= esof_ev;
      err_eof    <= eeof_ev;
      err_abort  <= abort_ev;
      if (word_vld) begin
        run_q  <= run_n;
        idle_q <= idle_n;
        if (is_ps) last_q <= cls;
        if (run_hit) begin
          prim_seq   <= class_to_prim(cls);
          link_state <= ((cls == WC_NOS) || (cls == WC_OLS)) ? LS_FAIL : LS_RESET;
        end else if (idle_hit) begin
          prim_seq   <= PS_NONE;
          link_state <= LS_UP;
        end
        if (cls == WC_SOF)              in_frame <= 1'b1;
        else if (cls == WC_EOF || is_ps) in_frame <= 1'b0;
        if (done_ev) frame_len <= (&len_q) ? len_q : len_q + LEN_ONE;
      end
    end
  end

`ifdef VI_FC_LINK_MON_STATS_EN
  logic fail_entry;
  assign fail_entry = run_hit && ((cls == WC_NOS) || (cls == WC_OLS)) && (link_state != LS_FAIL);

  // Events are counted in the same cycle they are detected so a coincident clear wins.
  vi_fc_sat_cnt #(.W(CNT_W)) u_stat_frames (
    .clk (clk), .rst (rst), .clr (stats_clr),
    .inc (done_ev && !stats_clr), .cnt (stat_frames)
  );
  vi_fc_sat_cnt #(.W(CNT_W)) u_stat_errs (
    .clk (clk), .rst (rst), .clr (stats_clr),
    .inc ((esof_ev || eeof_ev || abort_ev) && !stats_clr), .cnt (stat_errs)
  );
  vi_fc_sat_cnt #(.W(CNT_W)) u_stat_fails (
    .clk (clk), .rst (rst), .clr (stats_clr),
    .inc (fail_entry && !stats_clr), .cnt (stat_fails)
  );
`endif

endmodule

// File: tb/tb_vi_fc_link_mon.sv
// tb/tb_vi_fc_link_mon.sv - directed and randomized bench for vi_fc_link_mon against a reference model
module tb_vi_fc_link_mon;

  localparam int IDLE_RUN = 3;
  localparam int LEN_W    = 4;
  localparam int LEN_MAX  = (1 << LEN_W) - 1;
  // class numbering: 0 NOS, 1 OLS, 2 LR, 3 LRR, 4 SOF, 5 EOF, 6 IDLE, 7 OTHER
  localparam int C_NOS = 0, C_OLS = 1, C_LR = 2, C_LRR = 3;
  localparam int C_SOF = 4, C_EOF = 5, C_IDLE = 6, C_OTHER = 7;

  logic clk = 1'b0;
  logic rst, word_vld, sof, eof, idle, nos, ols, lr, lrr;
  logic [2:0]       prim_seq;
  logic [1:0]       link_state;
  logic             in_frame, frame_done, err_sof, err_eof, err_abort;
  logic [LEN_W-1:0] frame_len;
  logic             stats_clr;
`ifdef VI_FC_LINK_MON_STATS_EN
  logic [31:0] stat_frames, stat_errs, stat_fails;
`endif

  vi_fc_link_mon #(.IDLE_RUN(IDLE_RUN), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_vld   (word_vld),
    .sof        (sof),
    .eof        (eof),
    .idle       (idle),
    .nos        (nos),
    .ols        (ols),
    .lr         (lr),
    .lrr        (lrr),
    .prim_seq   (prim_seq),
    .link_state (link_state),
    .in_frame   (in_frame),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .err_sof    (err_sof),
    .err_eof    (err_eof),
`ifdef VI_FC_LINK_MON_STATS_EN
    .err_abort  (err_abort),
    .stats_clr  (stats_clr),
    .stat_frames(stat_frames),
    .stat_errs  (stat_errs),
    .stat_fails (stat_fails)
`else
    .err_abort  (err_abort)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int in_frame_hi = 0;

  // reference model state
  int m_hist[$];
  int m_idle_run, m_prim, m_link, m_in_frame, m_len, m_flen;
  int m_done, m_esof, m_eeof, m_abort;
  int m_frames, m_errs, m_fails;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [6:0] f);
    for (int i = 6; i >= 0; i--) if (f[i]) return 6 - i;
    return C_OTHER;
  endfunction

  function automatic logic [6:0] flags_of(input int c);
    logic [6:0] f;
    f = '0;
    if (c < 7) f[6 - c] = 1'b1;
    return f;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_idle_run = 0; m_prim = 0; m_link = 0; m_in_frame = 0; m_len = 0; m_flen = 0;
    m_done = 0; m_esof = 0; m_eeof = 0; m_abort = 0;
    m_frames = 0; m_errs = 0; m_fails = 0;
  endtask

  task automatic model_word(input logic vld, input logic [6:0] f, input logic clr);
    int c, old_link;
    logic seq3;
    m_done = 0; m_esof = 0; m_eeof = 0; m_abort = 0;
    if (!vld) return;
    c = cls_of(f);
    old_link = m_link;
    m_hist.push_back(c);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    m_idle_run = (c == C_IDLE) ? m_idle_run + 1 : 0;
    seq3 = (c <= C_LRR) && (m_hist.size() == 3) && (m_hist[0] == c) && (m_hist[1] == c);
    if (seq3) begin
      m_prim = c + 1;
      m_link = (c <= C_OLS) ? 1 : 2;
    end else if (m_idle_run >= IDLE_RUN) begin
      m_prim = 0;
      m_link = 3;
    end
    if (c == C_SOF) begin
      m_esof = m_in_frame; m_in_frame = 1; m_len = 1;
    end else if (c == C_EOF) begin
      if (m_in_frame) begin
        m_done = 1; m_flen = (m_len + 1 > LEN_MAX) ? LEN_MAX : m_len + 1; m_in_frame = 0;
      end else m_eeof = 1;
    end else if (c >= C_IDLE) begin
      if (m_in_frame && m_len < LEN_MAX) m_len++;
    end else begin
      m_abort = m_in_frame; m_in_frame = 0;
    end
    if (clr) begin
      m_frames = 0; m_errs = 0; m_fails = 0;
    end else begin
      m_frames += m_done;
      m_errs   += m_esof + m_eeof + m_abort;
      if (m_link == 1 && old_link != 1) m_fails++;
    end
  endtask

  task automatic check_all();
    check("prim_seq",   32'(prim_seq),   32'(m_prim));
    check("link_state", 32'(link_state), 32'(m_link));
    check("in_frame",   32'(in_frame),   32'(m_in_frame));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("frame_len",  32'(frame_len),  32'(m_flen));
    check("err_sof",    32'(err_sof),    32'(m_esof));
    check("err_eof",    32'(err_eof),    32'(m_eeof));
    check("err_abort",  32'(err_abort),  32'(m_abort));
`ifdef VI_FC_LINK_MON_STATS_EN
    check("stat_frames", stat_frames, 32'(m_frames));
    check("stat_errs",   stat_errs,   32'(m_errs));
    check("stat_fails",  stat_fails,  32'(m_fails));
`endif
    if (in_frame === 1'b1) in_frame_hi++;
  endtask

  task automatic apply(input logic vld, input logic [6:0] f, input logic clr);
    @(negedge clk);
    word_vld = vld;
    {nos, ols, lr, lrr, sof, eof, idle} = f;
    stats_clr = clr;
    model_word(vld, f, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic word(input int c);
    apply(1'b1, flags_of(c), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    word_vld = 1'b1;
    {nos, ols, lr, lrr, sof, eof, idle} = 7'b0000100;
    stats_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    word_vld = 1'b0;
  endtask

  initial begin
    int prev_c, c, r;
    rst = 1'b1; word_vld = 1'b0; stats_clr = 1'b0;
    {nos, ols, lr, lrr, sof, eof, idle} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // link comes up one cycle after the third idle
    word(C_IDLE); word(C_IDLE);
    check("link_not_yet_up", 32'(link_state), 32'd0);
    word(C_IDLE);
    check("link_up", 32'(link_state), 32'd3);

    // broken NOS run, then a full run, then recovery
    word(C_NOS); word(C_NOS); word(C_IDLE); word(C_NOS); word(C_NOS);
    check("nos_not_yet", 32'(prim_seq), 32'd0);
    word(C_NOS);
    check("nos_prim", 32'(prim_seq), 32'd1);
    check("nos_fail", 32'(link_state), 32'd1);
    repeat (3) word(C_IDLE);
    check("nos_recover", 32'(link_state), 32'd3);

    // SOF, 5 OTHER, EOF
    in_frame_hi = 0;
    word(C_SOF);
    repeat (5) word(C_OTHER);
    word(C_EOF);
    check("len7", 32'(frame_len), 32'd7);
    check("done7", 32'(frame_done), 32'd1);
    check("in_frame_cycles", 32'(in_frame_hi), 32'd6);

    // SOF restart, then lone EOF
    word(C_SOF); word(C_OTHER); word(C_SOF);
    check("err_sof_dir", 32'(err_sof), 32'd1);
    word(C_EOF);
    check("len2", 32'(frame_len), 32'd2);
    word(C_EOF);
    check("err_eof_dir", 32'(err_eof), 32'd1);

    // abort by LR, then LR sequence
    word(C_SOF); word(C_OTHER); word(C_LR);
    check("abort_dir", 32'(err_abort), 32'd1);
    word(C_LR); word(C_LR);
    check("lr_prim", 32'(prim_seq), 32'd3);
    check("lr_reset", 32'(link_state), 32'd2);

    // word_vld gaps inside a frame, and length saturation
    word(C_SOF); word(C_OTHER);
    repeat (4) apply(1'b0, 7'b0000010, 1'b0);
    word(C_EOF);
    check("gap_len", 32'(frame_len), 32'd3);
    word(C_SOF);
    repeat (20) word(C_IDLE);
    word(C_EOF);
    check("sat_len", 32'(frame_len), 32'(LEN_MAX));

    // reset mid-frame is silent
    word(C_SOF); word(C_OTHER);
    do_reset();
    word(C_EOF);

`ifdef VI_FC_LINK_MON_STATS_EN
    repeat (3) begin word(C_SOF); word(C_OTHER); word(C_EOF); end
    check("stat3", stat_frames, 32'd3);
    word(C_SOF);
    apply(1'b1, flags_of(C_EOF), 1'b1);
    check("stat_clr_wins", stat_frames, 32'd0);
`endif

    // randomized traffic
    prev_c = C_IDLE;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else if (r < 9) begin
        apply(1'b0, 7'($urandom_range(0, 127)), $urandom_range(0, 19) == 0);
      end else if (r < 20) begin
        apply(1'b1, 7'($urandom_range(0, 127)), $urandom_range(0, 19) == 0);
      end else begin
        c = ($urandom_range(0, 99) < 40) ? prev_c : $urandom_range(0, 9);
        if (c > 7) c = C_OTHER;
        prev_c = c;
        apply(1'b1, flags_of(c), $urandom_range(0, 29) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
